// File: rtl/spi_flash_seq.sv
// Operation-level sequencer for spi_flash_cmd: expands READ / PROGRAM / ERASE / RDID
// requests into WREN, opcode and RDSR-poll command sequences on the engine cmd port.
module spi_flash_seq #(
  parameter int unsigned POLL_GAP = 1000,
  parameter int unsigned POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_op,
  input  logic        i_op_valid,
  output logic        o_op_ready,
  input  logic [23:0] i_addr,
  input  logic [8:0]  i_len,
  output logic        o_wr_rd,
  input  logic [7:0]  i_wr_data,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_status,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ack,
  output logic [23:0] o_addr,
  output logic [8:0]  o_byte_size,
  input  logic        i_data_req,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREFETCH, S_WREN, S_WREN_WAIT, S_EXEC, S_EXEC_WAIT,
    S_GAP, S_RDSR, S_RDSR_WAIT, S_FIN
  } state_t;

  localparam logic [1:0]  OP_READ  = 2'd0;
  localparam logic [1:0]  OP_PROG  = 2'd1;
  localparam logic [1:0]  OP_ERASE = 2'd2;
  localparam logic [1:0]  OP_RDID  = 2'd3;
  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);
  localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 1);

  state_t      state;
  logic [1:0]  op;
  logic [23:0] req_addr;
  logic [8:0]  len;
  logic [8:0]  pop_cnt;
  logic        pop_pend;
  logic        pf_phase;
  logic        ack_hold;
  logic        wr_rd_q;
  logic [15:0] poll_cnt;
  logic [31:0] gap_cnt;

  logic        exec_phase;
  logic        data_pop;
  logic        ack;
  logic        is_rd_op;
  logic [7:0]  rdsr_val;
  logic [9:0]  page_end;
  logic [15:0] poll_next;

  function automatic logic [7:0] op_code(input logic [1:0] o);
    case (o)
      OP_READ:  op_code = 8'h03;
      OP_PROG:  op_code = 8'h02;
      OP_ERASE: op_code = 8'hD8;
      default:  op_code = 8'h9F;
    endcase
  endfunction

  assign exec_phase = (state == S_EXEC) || (state == S_EXEC_WAIT);
  assign is_rd_op   = (op == OP_READ) || (op == OP_RDID);
  // Pops are capped at len; the prefetch already counted as the first one.
  assign data_pop   = exec_phase && (op == OP_PROG) && i_data_req && (pop_cnt < len);
  assign o_wr_rd    = wr_rd_q | data_pop;
  // An ack seen in the same cycle as o_cmd_valid is remembered so the next
  // command still starts at least two cycles after the previous one.
  assign ack        = i_cmd_ack | ack_hold;
  assign rdsr_val   = i_data_valid ? i_data : o_status;
  assign page_end   = {2'b00, i_addr[7:0]} + {1'b0, i_len};
  assign poll_next  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op          <= OP_READ;
      req_addr    <= '0;
      len         <= '0;
      pop_cnt     <= '0;
      pop_pend    <= 1'b0;
      pf_phase    <= 1'b0;
      ack_hold    <= 1'b0;
      wr_rd_q     <= 1'b0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      o_op_ready  <= 1'b1;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_status    <= '0;
      o_cmd       <= '0;
      o_cmd_valid <= 1'b0;
      o_addr      <= '0;
      o_byte_size <= '0;
      o_data      <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      wr_rd_q     <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rd_valid  <= 1'b0;
      pop_pend    <= data_pop;
      if (data_pop) pop_cnt <= pop_cnt + 9'd1;
      if (pop_pend) o_data <= i_wr_data;
      if (i_data_valid && exec_phase && is_rd_op) begin
        o_rd_valid <= 1'b1;
        o_rd_data  <= i_data;
      end
      if (i_data_valid && ((state == S_RDSR) || (state == S_RDSR_WAIT)))
        o_status <= i_data;

      case (state)
        S_IDLE: begin
          if (i_op_valid) begin
            o_op_ready <= 1'b0;
            op         <= i_op;
            req_addr   <= i_addr;
            len        <= i_len;
            poll_cnt   <= '0;
            pop_cnt    <= '0;
            ack_hold   <= 1'b0;
            if (((i_op == OP_READ) || (i_op == OP_PROG)) && (i_len == 9'd0)) begin
              state  <= S_FIN;
              o_done <= 1'b1;
            end else if ((i_op == OP_PROG) && (page_end > 10'd256)) begin
              state <= S_FIN;
              o_err <= 1'b1;
            end else if (i_op == OP_PROG) begin
              state    <= S_PREFETCH;
              wr_rd_q  <= 1'b1;
              pf_phase <= 1'b0;
              pop_cnt  <= 9'd1;
            end else if (i_op == OP_ERASE) begin
              state       <= S_WREN;
              o_cmd       <= 8'h06;
              o_addr      <= i_addr;
              o_byte_size <= '0;
              o_cmd_valid <= 1'b1;
            end else begin
              state       <= S_EXEC;
              o_cmd       <= op_code(i_op);
              o_addr      <= i_addr;
              o_byte_size <= (i_op == OP_RDID) ? 9'd3 : i_len;
              o_cmd_valid <= 1'b1;
            end
          end
        end
        S_PREFETCH: begin
          if (!pf_phase) begin
            pf_phase <= 1'b1;
          end else begin
            o_data      <= i_wr_data;
            state       <= S_WREN;
            o_cmd       <= 8'h06;
            o_addr      <= req_addr;
            o_byte_size <= '0;
            o_cmd_valid <= 1'b1;
          end
        end
        S_WREN: begin
          ack_hold <= i_cmd_ack;
          state    <= S_WREN_WAIT;
        end
        S_WREN_WAIT: begin
          if (ack) begin
            ack_hold    <= 1'b0;
            state       <= S_EXEC;
            o_cmd       <= op_code(op);
            o_addr      <= req_addr;
            o_byte_size <= (op == OP_ERASE) ? 9'd0 : len;
            o_cmd_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          ack_hold <= i_cmd_ack;
          state    <= S_EXEC_WAIT;
        end
        S_EXEC_WAIT: begin
          if (ack) begin
            ack_hold <= 1'b0;
            if (is_rd_op) begin
              state  <= S_FIN;
              o_done <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state       <= S_RDSR;
            o_cmd       <= 8'h05;
            o_addr      <= req_addr;
            o_byte_size <= 9'd1;
            o_cmd_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        S_RDSR: begin
          ack_hold <= i_cmd_ack;
          state    <= S_RDSR_WAIT;
        end
        S_RDSR_WAIT: begin
          if (ack) begin
            ack_hold <= 1'b0;
            if (!rdsr_val[0]) begin
              state  <= S_FIN;
              o_done <= 1'b1;
            end else begin
              poll_cnt <= poll_next;
              if (poll_next >= POLL_LIM) begin
                state <= S_FIN;
                o_err <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end
          end
        end
        S_FIN: begin
          o_op_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_flash_seq.md
# spi_flash_seq

Operation-level sequencer for the SPI flash command engine (`spi_flash_cmd`). Accepts one high-level request at a time: read, page program, sector erase or read ID. Expands each request into the required flash command sequence (WREN, then the operation, then RDSR polling until WIP clears). Sits between the flash/DDR user logic and `spi_flash_cmd`, owns that engine's command port exclusively, and reports completion and errors.

## Interface
- `POLL_GAP`, 1000: idle clk cycles between consecutive RDSR polls.
- `POLL_MAX`, 65535: RDSR polls allowed before a timeout error (16-bit counter).
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `i_op` in 2: 0 = READ (03h), 1 = PROGRAM (02h), 2 = SECTOR ERASE (D8h), 3 = RDID (9Fh).
- `i_op_valid` in 1 / `o_op_ready` out 1: request handshake; accepted when both are high.
- `i_addr` in 24: flash byte address.
- `i_len` in 9: byte count, 0..256 (READ/PROGRAM; RDID uses a fixed 3; ignored for ERASE).
- `o_wr_rd` out 1: one-cycle pulse that pops the next program byte from the user FIFO.
- `i_wr_data` in 8: FIFO data, valid 1 cycle after `o_wr_rd`.
- `o_rd_data` out 8 / `o_rd_valid` out 1: read/RDID byte stream.
- `o_done` out 1 / `o_err` out 1: one-cycle completion pulses (mutually exclusive).
- `o_status` out 8: last RDSR value.
- `o_cmd` out 8, `o_cmd_valid` out 1, `i_cmd_ack` in 1, `o_addr` out 24, `o_byte_size` out 9: to the engine's cmd port.
- `i_data_req` in 1, `o_data` out 8: engine write-data request and the byte supplied to it.
- `i_data` in 8, `i_data_valid` in 1: engine read data.

## Operation
- **States:** IDLE, PREFETCH, WREN, WREN_WAIT, EXEC, EXEC_WAIT, GAP, RDSR, RDSR_WAIT, FIN.
- **IDLE:** `o_op_ready` = 1. On accept, latch `i_op`, `i_addr` and `i_len`, and drop `o_op_ready`.
- **Request checks at accept:**
  - `len` = 0 for READ or PROGRAM: FIN with `o_done`, no flash traffic.
  - PROGRAM with `addr[7:0] + len > 256` (page crossing): FIN with `o_err`, no flash traffic.
- **Routing after accept:**
  - READ and RDID go to EXEC.
  - PROGRAM goes to PREFETCH: pulse `o_wr_rd`, load `i_wr_data` into `o_data` the next cycle, then go to WREN.
  - ERASE goes to WREN.
- **Issuing a command:** pulse `o_cmd_valid` for exactly 1 cycle. Hold `o_cmd`, `o_addr` and `o_byte_size` stable until `i_cmd_ack`. Never re-pulse `o_cmd_valid` before that ack.
- **WREN:** `o_cmd` = 06h, `o_byte_size` = 0. On ack, go to EXEC.
- **EXEC:**
  - `o_cmd` = 03h / 02h / D8h / 9Fh.
  - `o_byte_size` = `len`, or 3 for RDID.
  - On ack: READ and RDID go to FIN; PROGRAM and ERASE go to GAP.
- **PROGRAM data:** on each `i_data_req` pulse, pulse `o_wr_rd` the same cycle and load `i_wr_data` into `o_data` the following cycle. Total pops equal `len`; the prefetch counts as the first pop.
- **READ / RDID data:** `o_rd_data` = `i_data` and `o_rd_valid` = `i_data_valid`, registered, 1-cycle latency. Gated to EXEC_WAIT of READ/RDID only. RDSR bytes are never forwarded.
- **GAP:** count `POLL_GAP` cycles, then go to RDSR.
- **RDSR:**
  - `o_cmd` = 05h, `o_byte_size` = 1.
  - On `i_data_valid`, capture `o_status`.
  - On ack: if `o_status[0]` = 0, go to FIN with `o_done`.
  - Otherwise increment the poll count. If the count reaches `POLL_MAX`, go to FIN with `o_err`; else go to GAP.
- **FIN:** pulse `o_done` or `o_err` for 1 cycle, then go to IDLE.
- **Reset** (any time, including mid-command): state returns to IDLE immediately and all counters clear. The engine is reset by the same reset source, so no partial command survives.

## Timing
- **Reset values:**
  - `o_op_ready` = 1.
  - `o_cmd_valid`, `o_wr_rd`, `o_rd_valid`, `o_done`, `o_err` = 0.
  - `o_cmd` = 00h, `o_addr` = 0, `o_byte_size` = 0, `o_data` = 0, `o_status` = 0, `o_rd_data` = 0.
- Accept in cycle N: `o_op_ready` = 0 in N+1. First `o_cmd_valid` in N+1 (READ/RDID/ERASE) or N+3 (PROGRAM, after prefetch).
- Consecutive `o_cmd_valid` pulses are at least 2 cycles apart; the next pulse comes no earlier than 1 cycle after `i_cmd_ack`.
- `o_data` is updated within 2 cycles of `i_data_req`. This requires the engine's `i_clk_div` ≥ 2.
- `o_done`/`o_err` pulse 1 cycle after the final ack. `o_op_ready` = 1 the cycle after that pulse.
- `i_op_valid` asserted while `o_op_ready` = 0 is ignored; there is no queuing.
- The poll counter saturates at `POLL_MAX`; the GAP counter is 32 bits wide.

## Test plan
- **RDID:** op 3 against a flash model returning EF 40 18 -> one cmd 9Fh with `o_byte_size` 3, `o_rd_data` EF/40/18 with 3 `o_rd_valid` pulses, then `o_done`.
- **PROGRAM:**
  - Stimulus: addr 0x001000, len 4, FIFO holding A1..A4; model WIP = 1 for the first 2 polls.
  - Command sequence: 06h, then 02h (`o_byte_size` 4), then 05h ×3.
  - Flash model receives A1..A4 in order and sees exactly 4 `o_wr_rd` pulses; `o_status` = 00h; `o_done`.
- **Page-crossing PROGRAM:** addr 0x0000F0, len 32 -> `o_err` with zero `o_cmd_valid` and zero `o_wr_rd`. READ with len 0 -> `o_done` with no traffic.
- **ERASE timeout:** `POLL_MAX` = 4, WIP stuck at 1 -> 06h, D8h (addr 0x010000), 4 RDSR polls, then `o_err`; `o_status` = 01h.
- **Reset mid-operation:** assert `rst` during a READ of len 256 while in EXEC_WAIT -> all outputs at reset values next cycle. A new RDID after release completes normally.
